// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: XLEN, M-extension funct3 encodings and muldiv FSM types.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam int unsigned MULDIV_CNT_W = $clog2(XLEN);

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift/accumulate registers shared by the iterative multiply and restoring divide.
module muldiv_datapath #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN-1:0] hi_nxt_o,
    output logic [XLEN-1:0] lo_nxt_o
);

    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Multiply: {hi,lo} holds partial product over the shifting multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, a_q};
        if (div_i) begin
            if (!diff[XLEN]) begin
                hi_nxt_o = diff[XLEN-1:0];
                lo_nxt_o = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt_o = shifted[XLEN-1:0];
                lo_nxt_o = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt_o = sum[XLEN:1];
            lo_nxt_o = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (load_i) begin
            a_q  <= a_i;
            hi_q <= '0;
            lo_q <= lo_i;
        end else if (step_i) begin
            hi_q <= hi_nxt_o;
            lo_q <= lo_nxt_o;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush.
// Optional: define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            busy_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    muldiv_state_t   state_q;
    logic [2:0]      op_q;
    logic            sa_q;
    logic            sb_q;
    logic [4:0]      rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic            accept;
    logic            in_div;
    logic            s1_in;
    logic            s2_in;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            fast_mul;
    logic [XLEN-1:0] fast_res;
    logic            dp_load;
    logic            dp_step;
    logic            dp_div;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] calc_res;

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign busy_o      = (state_q != IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign in_div      = funct3_i[2];

    always_comb begin
        s1_in = 1'b0;
        s2_in = 1'b0;
        case (funct3_i)
            FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM: begin
                s1_in = 1'b1;
                s2_in = 1'b1;
            end
            FUNCT3_MULHSU: s1_in = 1'b1;
            default: ;
        endcase
    end

    assign sign_a = s1_in && rs1_i[XLEN-1];
    assign sign_b = s2_in && rs2_i[XLEN-1];
    assign mag_a  = sign_a ? -rs1_i : rs1_i;
    assign mag_b  = sign_b ? -rs2_i : rs2_i;

    // Divide-by-zero and signed overflow bypass the datapath entirely.
    always_comb begin
        div_zero = in_div && (rs2_i == '0);
        div_ovf  = ((funct3_i == FUNCT3_DIV) || (funct3_i == FUNCT3_REM)) &&
                   (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = funct3_i[1] ? rs1_i : '1;
        else
            special_res = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa;
    logic signed [XLEN:0]     fb;
    logic signed [2*XLEN+1:0] fp;

    assign fa       = {s1_in && rs1_i[XLEN-1], rs1_i};
    assign fb       = {s2_in && rs2_i[XLEN-1], rs2_i};
    assign fp       = fa * fb;
    assign fast_mul = !in_div;
    assign fast_res = (funct3_i == FUNCT3_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    assign dp_load = accept && !special && !fast_mul;
    assign dp_step = (state_q == CALC);
    assign dp_div  = op_q[2];

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (dp_load),
        .step_i   (dp_step),
        .div_i    (dp_div),
        .a_i      (in_div ? mag_b : mag_a),
        .lo_i     (in_div ? mag_a : mag_b),
        .hi_nxt_o (hi_nxt),
        .lo_nxt_o (lo_nxt)
    );

    // Sign fix-up uses the final step's combinational value so the result registers on the last CALC edge.
    always_comb begin
        prod = {hi_nxt, lo_nxt};
        if (sa_q ^ sb_q)
            prod = -prod;
        quot = (sa_q ^ sb_q) ? -lo_nxt : lo_nxt;
        rem  = sa_q ? -hi_nxt : hi_nxt;
        case (op_q)
            FUNCT3_MUL:                                calc_res = prod[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU:  calc_res = prod[2*XLEN-1:XLEN];
            FUNCT3_DIV, FUNCT3_DIVU:                   calc_res = quot;
            default:                                   calc_res = rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            op_q         <= '0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            rd_q         <= '0;
            cnt_q        <= '0;
            resp_valid_o <= 1'b0;
            result_o     <= '0;
            rd_o         <= '0;
        end else if (flush_i) begin
            state_q      <= IDLE;
            resp_valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= funct3_i;
                        sa_q <= sign_a;
                        sb_q <= sign_b;
                        rd_q <= rd_i;
                        if (special || fast_mul) begin
                            result_o     <= special ? special_res : fast_res;
                            rd_o         <= rd_i;
                            resp_valid_o <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            cnt_q   <= CNT_W'(XLEN - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        result_o     <= calc_res;
                        rd_o         <= rd_q;
                        resp_valid_o <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, handshake/flush/reset sequences, random ops vs reference model.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .funct3_i     (funct3),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .rd_i         (rd_in),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_o     (result),
        .rd_o         (rd_out),
        .busy_o       (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference semantics of RV32M, written with 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!f3[2] && FAST) return 1;
        return 33;
    endfunction

    // Issue one op, wait (bounded) for the response, then complete the handshake.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat);
        funct3 = f3; rs1 = a; rs2 = b; rd_in = rd; req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        rdo = rd_out;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("valid_clear_after_hs", resp_valid, 0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        vec_t        vecs[10];
        logic [31:0] res;
        logic [31:0] held_res;
        logic [4:0]  rdo;
        logic [4:0]  held_rd;
        int          lat;
        int          mul_lat;
        bit          saw_valid;

        mul_lat = FAST ? 1 : 33;
        vecs[0] = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, mul_lat};
        vecs[1] = '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, mul_lat};
        vecs[2] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, mul_lat};
        vecs[3] = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[4] = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[5] = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[6] = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[7] = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1};
        vecs[8] = '{3'd7, 32'd100,        32'd0,         32'h64,        1};
        vecs[9] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};

        // Reset state
        #2;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", rd_out, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), res, rdo, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_rd", i), rdo, 5'(i + 1));
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Response held back for 5 cycles in DONE
        funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd9; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("stall_latency", lat, 33);
        held_res = result;
        held_rd = rd_out;
        chk("stall_result", held_res, 32'd14);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid_held", resp_valid, 1);
            chk("stall_result_held", result, held_res);
            chk("stall_rd_held", rd_out, held_rd);
            chk("stall_req_ready_low", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        chk("post_hs_idle", busy, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd10, res, rdo, lat);
        chk("back_to_back_result", res, 32'd2);
        chk("back_to_back_rd", rdo, 5'd10);

        // Flush at CALC cycle 10
        funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd3; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1; chk("pre_flush_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_idle", busy, 0);
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (resp_valid) saw_valid = 1'b1;
        end
        chk("flush_no_response", saw_valid, 0);

        // Flush concurrent with a request in IDLE
        funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd4; req_valid = 1'b1; flush = 1'b1;
        #1; chk("flush_blocks_ready", req_ready, 0);
        @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
        chk("flush_no_accept", busy, 0);

        // Reset mid-CALC
        funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd6; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", resp_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_rd", rd_out, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", req_ready, 1);
        run_op(3'd0, 32'd3, 32'd5, 5'd7, res, rdo, lat);
        chk("post_rst_mul", res, 32'd15);
        chk("post_rst_latency", lat, mul_lat);

        // Random ops against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            f3 = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            rd = 5'($urandom_range(0, 31));
            run_op(f3, a, b, rd, res, rdo, lat);
            chk($sformatf("rnd%0d_f%0d_%0h_%0h", n, f3, a, b), res, ref_result(f3, a, b));
            chk($sformatf("rnd%0d_rd", n), rdo, rd);
            chk($sformatf("rnd%0d_latency", n), lat, ref_latency(f3, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default riscv_pkg::XLEN (32), operand/result width.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  in  1  request valid.
REQ-005 SHALL have port req_ready_o  out  1  request ready.
REQ-006 SHALL have port funct3_i  in  3  M-extension op, encoded as the FUNCT3_MUL..FUNCT3_REMU constants.
REQ-007 SHALL have ports rs1_i and rs2_i  in  XLEN  operands.
REQ-008 SHALL have port rd_i  in  5  destination tag, returned unchanged.
REQ-009 SHALL have port flush_i  in  1  abort of the in-flight operation.
REQ-010 SHALL have port resp_valid_o  out  1  result valid.
REQ-011 SHALL have port resp_ready_i  in  1  result consumed.
REQ-012 SHALL have ports result_o (out, XLEN) and rd_o (out, 5) for the response data.
REQ-013 SHALL have port busy_o  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL drive req_ready_o = (state==IDLE) && !flush_i; a request is accepted on an edge where req_valid_i && req_ready_o.
REQ-016 SHALL latch funct3, rd and operand signs on accept and convert signed operands to magnitudes; signed per op: MULH/DIV/REM both operands, MULHSU rs1 only, others none.
REQ-017 SHALL, on accept, go IDLE->DONE directly when an op special case applies:
  - DIV/DIVU with rs2==0: quotient 0xFFFFFFFF.
  - REM/REMU with rs2==0: result rs1.
  - DIV with rs1==0x80000000 and rs2==0xFFFFFFFF: result 0x80000000; REM in the same case: result 0.
  Otherwise IDLE->CALC.
REQ-018 SHALL, in CALC, perform one radix-2 step per cycle (shift-add multiply or restoring divide) for exactly XLEN cycles, counted by a $clog2(XLEN)-bit down-counter.
REQ-019 SHALL, on the last CALC cycle, apply sign correction (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa), select the result (MUL low half, MULH* high half, DIV* quotient, REM* remainder), register it into result_o, and enter DONE.
REQ-020 SHALL give resp_valid_o exactly XLEN+1 edges after the accept edge for iterative ops, and 1 edge after for special cases.
REQ-021 SHALL hold resp_valid_o, result_o and rd_o stable in DONE until resp_ready_i is high; the handshake edge returns to IDLE, and a new accept is possible only on the following cycle.
REQ-022 SHALL have flush_i return the FSM to IDLE on the next edge from any state and clear resp_valid_o; flush takes priority over both accept and response handshake in the same cycle.
REQ-023 SHALL clear resp_valid_o on IDLE re-entry and leave result_o and rd_o holding their last values.

Reset
REQ-024 SHALL, while rst_ni is low, immediately force state IDLE, resp_valid_o=0, result_o=0, rd_o=0, busy_o=0, counter=0, and all datapath registers to 0.
REQ-025 SHALL have reset asserted mid-CALC or mid-DONE discard the operation with no response; req_ready_o is 1 on the first cycle after release.

Configuration
REQ-026 SHALL, with MULDIV_FAST_MUL_EN defined, compute MUL/MULH/MULHSU/MULHU with a combinational (XLEN+1)x(XLEN+1) signed multiply, going IDLE->DONE with 1-edge latency.
REQ-027 SHALL, without MULDIV_FAST_MUL_EN, run all multiplies iteratively per REQ-018; division is always iterative.

Structure
REQ-028 SHALL add to riscv_pkg: muldiv_state_t enum {IDLE, CALC, DONE}, and a constant MULDIV_CNT_W = $clog2(XLEN).
REQ-029 SHALL place the shift/accumulate registers and step logic in a sub-module muldiv_datapath; the FSM, counter, handshake and sign fix-up stay in muldiv_unit.

Verification
REQ-030 SHALL cover: MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; latency 33 edges, or 1 edge with MULDIV_FAST_MUL_EN.
REQ-031 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU same operands -> 2.
REQ-032 SHALL cover: DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 0x64; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with resp_valid_o 1 edge after accept.
REQ-033 SHALL cover: resp_ready_i held low 5 cycles in DONE -> result_o and rd_o stable, req_ready_o=0; accept in the cycle after the handshake.
REQ-034 SHALL cover: flush_i at CALC cycle 10 -> IDLE next edge, no resp_valid_o; flush_i concurrent with req_valid_i in IDLE -> no accept.
REQ-035 SHALL cover: rst_ni pulsed low mid-CALC -> outputs 0 immediately; a subsequent MUL 3*5 -> 15 with normal latency.
